// File: rtl/vga_range_ctrl.sv
// vga_range_ctrl: auto-ranging VGA gain stepper with hysteresis, overflow back-off and settle veto
module vga_range_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_MIN   = 0,
    parameter int GAIN_MAX   = 31,
    parameter int GAIN_INIT  = 16,
    parameter int HI_TH      = 28000,
    parameter int LO_TH      = 8000,
    parameter int N_HYST     = 4,
    parameter int OVF_STEP   = 3,
    parameter int SETTLE_CYC = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  auto_en,
    input  logic [4:0]            manual_gain,
    input  logic                  evt_rdy,
    input  logic                  cal_flag,
    input  logic [DATA_WIDTH-1:0] max_a,
    input  logic [DATA_WIDTH-1:0] max_b,
    input  logic [DATA_WIDTH-1:0] max_c,
    input  logic [DATA_WIDTH-1:0] max_d,
    input  logic                  ovf_a,
    input  logic                  ovf_b,
    input  logic                  ovf_c,
    input  logic                  ovf_d,
    output logic [4:0]            vga_gain,
    output logic                  gain_upd,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, EVAL, ADJUST, SETTLE} state_t;
    localparam logic signed [6:0]        G_MIN  = 7'(GAIN_MIN);
    localparam logic signed [6:0]        G_MAX  = 7'(GAIN_MAX);
    localparam logic signed [6:0]        O_STEP = 7'(OVF_STEP);
    localparam logic [DATA_WIDTH-1:0]    HI     = DATA_WIDTH'(HI_TH);
    localparam logic [DATA_WIDTH-1:0]    LO     = DATA_WIDTH'(LO_TH);
    localparam logic [7:0]               NH     = 8'(N_HYST);
    localparam logic [15:0]              SC     = 16'(SETTLE_CYC - 1);
    state_t                state, state_n;
    logic [4:0]            gain_n, new_gain, new_gain_n;
    logic                  gain_upd_n, busy_n, ovf, ovf_n, chg;
    logic [7:0]            hi_cnt, lo_cnt, hi_n, lo_n, hi_inc, lo_inc;
    logic [15:0]           settle_cnt, settle_n;
    logic [DATA_WIDTH-1:0] peak, peak_n, pk_ab, pk_cd, pk_all;
    // 7-bit signed keeps both gain-OVF_STEP below zero and GAIN_MAX+1 from wrapping
    logic signed [6:0]     g, cand, clamped;
    always_comb begin
        pk_ab      = max_a >= max_b ? max_a : max_b;
        pk_cd      = max_c >= max_d ? max_c : max_d;
        pk_all     = pk_ab >= pk_cd ? pk_ab : pk_cd;
        g          = signed'({2'b00, vga_gain});
        hi_inc     = hi_cnt + 8'd1;
        lo_inc     = lo_cnt + 8'd1;
        state_n    = state;
        gain_n     = vga_gain;
        gain_upd_n = 1'b0;
        busy_n     = busy;
        hi_n       = hi_cnt;
        lo_n       = lo_cnt;
        settle_n   = settle_cnt;
        peak_n     = peak;
        ovf_n      = ovf;
        new_gain_n = new_gain;
        cand       = g;
        chg        = 1'b0;
        case (state)
            IDLE: if (evt_rdy && !cal_flag && auto_en) begin
                peak_n  = pk_all;
                ovf_n   = ovf_a | ovf_b | ovf_c | ovf_d;
                state_n = EVAL;
            end
            EVAL: begin
                state_n = IDLE;
                if (ovf) begin
                    cand = g - O_STEP;
                    chg  = 1'b1;
                    hi_n = '0;
                    lo_n = '0;
                end else if (peak >= HI) begin
                    lo_n = '0;
                    hi_n = hi_inc >= NH ? '0 : hi_inc;
                    chg  = hi_inc >= NH;
                    cand = chg ? g - 7'sd1 : g;
                end else if (peak < LO) begin
                    hi_n = '0;
                    lo_n = lo_inc >= NH ? '0 : lo_inc;
                    chg  = lo_inc >= NH;
                    cand = chg ? g + 7'sd1 : g;
                end else begin
                    hi_n = '0;
                    lo_n = '0;
                end
                if (chg && new_gain_n != vga_gain) state_n = ADJUST;
            end
            ADJUST: begin
                gain_n     = new_gain;
                gain_upd_n = 1'b1;
                busy_n     = 1'b1;
                settle_n   = SC;
                state_n    = SETTLE;
            end
            default: begin
                busy_n   = settle_cnt != 16'd0;
                state_n  = settle_cnt == 16'd0 ? IDLE : SETTLE;
                settle_n = settle_cnt == 16'd0 ? settle_cnt : settle_cnt - 16'd1;
            end
        endcase
        clamped = cand < G_MIN ? G_MIN : cand > G_MAX ? G_MAX : cand;
        if (state == EVAL) new_gain_n = clamped[4:0];
        if (state == EVAL && chg) state_n = clamped[4:0] != vga_gain ? ADJUST : IDLE;
        if (!auto_en) begin
            gain_n     = manual_gain;
            state_n    = IDLE;
            hi_n       = '0;
            lo_n       = '0;
            busy_n     = 1'b0;
            gain_upd_n = 1'b0;
            settle_n   = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vga_gain   <= 5'(GAIN_INIT);
            gain_upd   <= 1'b0;
            busy       <= 1'b0;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            settle_cnt <= '0;
            peak       <= '0;
            ovf        <= 1'b0;
            new_gain   <= 5'(GAIN_INIT);
        end else begin
            state      <= state_n;
            vga_gain   <= gain_n;
            gain_upd   <= gain_upd_n;
            busy       <= busy_n;
            hi_cnt     <= hi_n;
            lo_cnt     <= lo_n;
            settle_cnt <= settle_n;
            peak       <= peak_n;
            ovf        <= ovf_n;
            new_gain   <= new_gain_n;
        end
    end
endmodule

// File: tb/tb_vga_range_ctrl.sv
// tb_vga_range_ctrl: table-driven event vectors with a queue scoreboard plus settle/manual/reset sequences
module tb_vga_range_ctrl;
    logic        clk = 1'b0, rst = 1'b1, auto_en = 1'b1, evt_rdy = 1'b0, cal_flag = 1'b0;
    logic [4:0]  manual_gain = 5'd0;
    logic [15:0] max_a = '0, max_b = '0, max_c = '0, max_d = '0;
    logic        ovf_a = 1'b0, ovf_b = 1'b0, ovf_c = 1'b0, ovf_d = 1'b0;
    logic [4:0]  vga_gain;
    logic        gain_upd, busy;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {int pre; int ch; int pk; logic [3:0] ov; bit cal; int eg; bit eu;} vec_t;
    typedef struct {int g; int u;} exp_t;
    vec_t tbl[$];
    exp_t sbq[$];

    vga_range_ctrl dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .manual_gain(manual_gain),
        .evt_rdy(evt_rdy), .cal_flag(cal_flag),
        .max_a(max_a), .max_b(max_b), .max_c(max_c), .max_d(max_d),
        .ovf_a(ovf_a), .ovf_b(ovf_b), .ovf_c(ovf_c), .ovf_d(ovf_d),
        .vga_gain(vga_gain), .gain_upd(gain_upd), .busy(busy)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int pre, input int ch, input int pk, input logic [3:0] ov,
                       input bit cal, input int eg, input bit eu);
        tbl.push_back('{pre, ch, pk, ov, cal, eg, eu});
    endtask

    task automatic preset(input int v);
        @(negedge clk);
        auto_en = 1'b0;
        manual_gain = 5'(v);
        @(negedge clk);
        auto_en = 1'b1;
    endtask

    // Peak goes on channel ch, the rest carry a quarter of it, so max selection is exercised
    task automatic evt(input string tag, input int ch, input int pk, input logic [3:0] ov,
                       input bit cal, input int eg, input bit eu);
        exp_t e;
        logic [15:0] p, q;
        p = 16'(pk);
        q = p >> 2;
        @(negedge clk);
        max_a = ch == 0 ? p : q;
        max_b = ch == 1 ? p : q;
        max_c = ch == 2 ? p : q;
        max_d = ch == 3 ? p : q;
        {ovf_a, ovf_b, ovf_c, ovf_d} = ov;
        cal_flag = cal;
        evt_rdy = 1'b1;
        sbq.push_back('{eg, int'(eu)});
        @(negedge clk);
        evt_rdy = 1'b0;
        cal_flag = 1'b0;
        {ovf_a, ovf_b, ovf_c, ovf_d} = 4'b0000;
        repeat (2) @(negedge clk);
        e = sbq.pop_front();
        chk({tag, "_gain"}, int'(vga_gain), e.g);
        chk({tag, "_upd"}, int'(gain_upd), e.u);
    endtask

    task automatic wait_settle(input string tag);
        int c;
        c = 1;
        @(negedge clk);
        chk({tag, "_upd_drop"}, int'(gain_upd), 0);
        while (busy && c < 300) begin
            c++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, c, 100);
    endtask

    initial begin
        int c;
        add(-1, 2, 1000, 4'b0010, 0, 13, 1);
        for (int i = 0; i < 3; i++) add(-1, 0, 30000, 4'b0000, 0, 13, 0);
        add(-1, 1, 15000, 4'b0000, 0, 13, 0);
        for (int i = 0; i < 3; i++) add(-1, 3, 30000, 4'b0000, 0, 13, 0);
        add(-1, 0, 30000, 4'b0000, 0, 12, 1);
        add(1, 0, 20000, 4'b1000, 0, 0, 1);
        add(-1, 3, 20000, 4'b0001, 0, 0, 0);
        add(30, 1, 5000, 4'b0000, 0, 30, 0);
        add(-1, 1, 5000, 4'b0000, 0, 30, 0);
        add(-1, 1, 5000, 4'b0000, 0, 30, 0);
        add(-1, 1, 5000, 4'b0000, 0, 31, 1);
        for (int i = 0; i < 4; i++) add(-1, 2, 5000, 4'b0000, 0, 31, 0);
        add(20, 0, 30000, 4'b0000, 0, 20, 0);
        add(-1, 0, 30000, 4'b0000, 0, 20, 0);
        add(-1, 0, 30000, 4'b0000, 0, 20, 0);
        add(-1, 0, 30000, 4'b0000, 1, 20, 0);
        add(-1, 0, 30000, 4'b0000, 1, 20, 0);
        add(-1, 0, 30000, 4'b0000, 0, 19, 1);
        add(10, 1, 28000, 4'b0000, 0, 10, 0);
        add(-1, 1, 28000, 4'b0000, 0, 10, 0);
        add(-1, 1, 28000, 4'b0000, 0, 10, 0);
        add(-1, 1, 28000, 4'b0000, 0, 9, 1);
        add(10, 2, 7999, 4'b0000, 0, 10, 0);
        add(-1, 2, 7999, 4'b0000, 0, 10, 0);
        add(-1, 2, 7999, 4'b0000, 0, 10, 0);
        add(-1, 2, 8000, 4'b0000, 0, 10, 0);
        for (int i = 0; i < 3; i++) add(-1, 3, 7999, 4'b0000, 0, 10, 0);
        add(-1, 3, 7999, 4'b0000, 0, 11, 1);
        add(10, 0, 28000, 4'b0000, 0, 10, 0);
        add(-1, 0, 28000, 4'b0000, 0, 10, 0);
        add(-1, 0, 28000, 4'b0000, 0, 10, 0);
        add(-1, 0, 27999, 4'b0000, 0, 10, 0);
        add(-1, 0, 28000, 4'b0000, 0, 10, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_gain", int'(vga_gain), 16);
        chk("reset_busy", int'(busy), 0);
        chk("reset_upd", int'(gain_upd), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pre >= 0) preset(tbl[i].pre);
            evt($sformatf("v%0d", i), tbl[i].ch, tbl[i].pk, tbl[i].ov, tbl[i].cal, tbl[i].eg, tbl[i].eu);
            if (tbl[i].eu) begin
                chk($sformatf("v%0d_busy_on", i), int'(busy), 1);
                wait_settle($sformatf("v%0d", i));
            end else begin
                chk($sformatf("v%0d_busy_off", i), int'(busy), 0);
            end
        end

        preset(20);
        for (int i = 0; i < 3; i++) evt("settle_pre", 1, 2000, 4'b0000, 0, 20, 0);
        evt("settle_step", 1, 2000, 4'b0000, 0, 21, 1);
        for (int i = 0; i < 3; i++) evt("settle_evt", 1, 2000, 4'b0000, 0, 21, 0);
        chk("settle_still_busy", int'(busy), 1);
        c = 0;
        while (busy && c < 300) begin
            c++;
            @(negedge clk);
        end
        chk("settle_done", int'(busy), 0);
        evt("settle_after", 1, 2000, 4'b0000, 0, 21, 0);

        evt("manual_ovf", 0, 100, 4'b0100, 0, 18, 1);
        repeat (10) @(negedge clk);
        auto_en = 1'b0;
        manual_gain = 5'd7;
        @(negedge clk);
        chk("manual_gain", int'(vga_gain), 7);
        chk("manual_busy", int'(busy), 0);
        chk("manual_upd", int'(gain_upd), 0);
        auto_en = 1'b1;

        evt("rst_ovf", 3, 100, 4'b0001, 0, 4, 1);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_gain", int'(vga_gain), 16);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_upd", int'(gain_upd), 0);
        evt("post_rst", 2, 100, 4'b0010, 0, 13, 1);
        wait_settle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
